// File: rtl/wordle_pkg.sv
// Shared colour codes and board geometry for the Wordle VGA grid renderer.
package wordle_pkg;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  localparam int ROWS  = 6;
  localparam int COLS  = 5;
  localparam int X0    = 224;
  localparam int Y0    = 8;
  localparam int TILE  = 40;
  localparam int PITCH = 48;

  localparam int BLINK_FRAMES = 30;

  // Result of mapping one pixel onto the tile grid.
  typedef struct packed {
    logic       hit;
    logic       on_edge;
    logic [2:0] row;
    logic [2:0] col;
  } tile_pos_t;

endpackage

// File: rtl/wordle_tile_decode.sv
// Combinational pixel-to-tile mapper: row/col by constant-threshold compares, no divider.
module wordle_tile_decode
  import wordle_pkg::*;
#(
  parameter int X_ORG = wordle_pkg::X0,
  parameter int Y_ORG = wordle_pkg::Y0,
  parameter int SPAN  = wordle_pkg::TILE,
  parameter int STEP  = wordle_pkg::PITCH,
  parameter int NCOL  = wordle_pkg::COLS,
  parameter int NROW  = wordle_pkg::ROWS
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  output tile_pos_t  pos
);

  logic [9:0] ox, oy, wx, wy;
  logic [2:0] col, row;
  logic       in_x, in_y;

  always_comb begin
    ox = px - 10'(X_ORG);
    oy = py - 10'(Y_ORG);
    col = '0;
    row = '0;
    wx = ox;
    wy = oy;
    // Index saturates at NCOL/NROW, which marks "beyond the grid".
    for (int i = 1; i <= NCOL; i++) begin
      if (ox >= 10'(i * STEP)) begin
        col = 3'(i);
        wx  = ox - 10'(i * STEP);
      end
    end
    for (int j = 1; j <= NROW; j++) begin
      if (oy >= 10'(j * STEP)) begin
        row = 3'(j);
        wy  = oy - 10'(j * STEP);
      end
    end
    in_x = (px >= 10'(X_ORG)) && (col < 3'(NCOL)) && (wx >= 10'd1) && (wx <= 10'(SPAN - 1));
    in_y = (py >= 10'(Y_ORG)) && (row < 3'(NROW)) && (wy >= 10'd1) && (wy <= 10'(SPAN - 1));
    pos.hit     = in_x && in_y;
    pos.on_edge = pos.hit && ((wx == 10'd1) || (wx == 10'(SPAN - 1)) ||
                              (wy == 10'd1) || (wy == 10'(SPAN - 1)));
    pos.row     = row;
    pos.col     = col;
  end

endmodule

// File: rtl/wordle_grid_renderer.sv
// Three-stage VGA pixel pipeline: tile decode, grid RAM address, colour select.
module wordle_grid_renderer
  import wordle_pkg::*;
#(
  parameter int X0_PIX       = wordle_pkg::X0,
  parameter int Y0_PIX       = wordle_pkg::Y0,
  parameter int TILE_PIX     = wordle_pkg::TILE,
  parameter int PITCH_PIX    = wordle_pkg::PITCH,
  parameter int N_ROWS       = wordle_pkg::ROWS,
  parameter int N_COLS       = wordle_pkg::COLS,
  parameter int BLINK_PERIOD = wordle_pkg::BLINK_FRAMES
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  output logic [4:0] rd_addr,
  input  logic [2:0] rd_data,
  input  logic       cursor_en,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_h_sync,
  output logic       vga_v_sync
);

  localparam int CW = $clog2(BLINK_PERIOD);

  tile_pos_t pos;

  logic       s0_hit, s0_edge, s0_cur, s0_de, s0_hs, s0_vs;
  logic [2:0] s0_row, s0_col;
  logic       s1_hit, s1_edge, s1_cur, s1_de, s1_hs, s1_vs;
  logic [2:0] rgb;

  logic          v_prev;
  logic [CW-1:0] frame_cnt;
  logic          blink_phase;

  wordle_tile_decode #(
    .X_ORG(X0_PIX), .Y_ORG(Y0_PIX), .SPAN(TILE_PIX),
    .STEP(PITCH_PIX), .NCOL(N_COLS), .NROW(N_ROWS)
  ) u_decode (
    .px (CounterX),
    .py (CounterY),
    .pos(pos)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s0_hit  <= 1'b0;
      s0_edge <= 1'b0;
      s0_cur  <= 1'b0;
      s0_de   <= 1'b0;
      s0_hs   <= 1'b1;
      s0_vs   <= 1'b1;
      s0_row  <= '0;
      s0_col  <= '0;
      s1_hit  <= 1'b0;
      s1_edge <= 1'b0;
      s1_cur  <= 1'b0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      rd_addr <= '0;
      rgb     <= COL_BLACK;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else begin
      s0_hit  <= pos.hit;
      s0_edge <= pos.on_edge;
      s0_cur  <= cursor_en && (pos.row == cursor_row) && (pos.col == cursor_col);
      s0_de   <= inDisplayArea;
      s0_hs   <= h_sync_in;
      s0_vs   <= v_sync_in;
      s0_row  <= pos.row;
      s0_col  <= pos.col;

      if (s0_hit) rd_addr <= {2'b00, s0_row} * 5'(N_COLS) + {2'b00, s0_col};
      s1_hit  <= s0_hit;
      s1_edge <= s0_edge;
      s1_cur  <= s0_cur;
      s1_de   <= s0_de;
      s1_hs   <= s0_hs;
      s1_vs   <= s0_vs;

      // rd_data here belongs to the address registered on the previous edge.
      if (!s1_de || !s1_hit)                   rgb <= COL_BLACK;
      else if (s1_edge && s1_cur && blink_phase) rgb <= COL_YELLOW;
      else if (s1_edge && rd_data == COL_BLACK)  rgb <= COL_WHITE;
      else                                       rgb <= rd_data;
      vga_h_sync <= s1_hs;
      vga_v_sync <= s1_vs;
    end
  end

  // Cursor blink: count v_sync falling edges, toggle phase every BLINK_PERIOD frames.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      v_prev      <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      v_prev <= v_sync_in;
      if (!cursor_en) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (v_prev && !v_sync_in) begin
        if (frame_cnt == CW'(BLINK_PERIOD - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;

endmodule
